main_mem_arbiter: RTL and testbench

MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

---
 rtl/main_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_main_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single MainMem port.
// Port 0 is instruction fetch and port 1 is data access. One transaction is
// in flight at a time. The winner's request fields are latched into holding
// registers at grant, and a stuck memory is aborted after TIMEOUT_CYCLES
// wait cycles.
module main_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_req_0,
   input  logic        in_req_1,
   input  logic [31:0] in_addr_0,
   input  logic [31:0] in_addr_1,
   input  logic        in_we_0,
   input  logic        in_we_1,
   input  logic [31:0] in_wdata_0,
   input  logic [31:0] in_wdata_1,
   output logic        out_done_0,
   output logic        out_done_1,
   output logic [31:0] out_rdata_0,
   output logic [31:0] out_rdata_1,
   output logic        out_timeout,
   output logic        out_mem_req,
   output logic        out_mem_we,
   output logic [31:0] out_mem_addr,
   output logic [31:0] out_mem_wdata,
   input  logic        in_mem_wait,
   input  logic [31:0] in_mem_rdata
);

   localparam int unsigned DW      = 32;
   localparam int unsigned AW      = 32;
   localparam int unsigned CW      = 8;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_d;

   // Index of the port owning the current transaction, and the round-robin pointer.
   logic            grant;
   logic            grant_d;
   logic            last_grant;
   logic            last_grant_d;

   logic [CW-1:0]   wait_cnt;
   logic [CW-1:0]   wait_cnt_d;

   // Next values of the registered outputs; the mem_* outputs are the holding registers.
   logic            mem_req_d;
   logic            mem_we_d;
   logic [AW-1:0]   mem_addr_d;
   logic [DW-1:0]   mem_wdata_d;
   logic            done_0_d;
   logic            done_1_d;
   logic [DW-1:0]   rdata_0_d;
   logic [DW-1:0]   rdata_1_d;
   logic            timeout_d;

   logic            win_c;
   logic [CW-1:0]   cnt_inc_c;
   logic            timeout_hit_c;

   // Round-robin winner: a lone request wins; a tie goes to the port not granted last.
   assign win_c = (in_req_0 && in_req_1) ? ~last_grant : in_req_1;

   // The wait counter saturates rather than wrapping.
   assign cnt_inc_c = (wait_cnt == CW'(CNT_MAX)) ? wait_cnt : wait_cnt + CW'(1);

   // The abort fires on the WAIT cycle that brings the count to TIMEOUT_CYCLES.
   assign timeout_hit_c = (32'(cnt_inc_c) >= TIMEOUT_CYCLES);

   // Next-state and next-output logic. Holding registers change only at grant.
   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      wait_cnt_d   = wait_cnt;
      mem_req_d    = 1'b0;
      mem_we_d     = out_mem_we;
      mem_addr_d   = out_mem_addr;
      mem_wdata_d  = out_mem_wdata;
      done_0_d     = 1'b0;
      done_1_d     = 1'b0;
      rdata_0_d    = out_rdata_0;
      rdata_1_d    = out_rdata_1;
      timeout_d    = out_timeout;

      unique case (state)
         IDLE: begin
            // Grant only once MainMem is idle, so an abandoned access drains first.
            if (!in_mem_wait && (in_req_0 || in_req_1)) begin
               grant_d      = win_c;
               last_grant_d = win_c;
               mem_addr_d   = win_c ? in_addr_1  : in_addr_0;
               mem_we_d     = win_c ? in_we_1    : in_we_0;
               mem_wdata_d  = win_c ? in_wdata_1 : in_wdata_0;
               wait_cnt_d   = '0;
               mem_req_d    = 1'b1;
               state_d      = ISSUE;
            end
         end

         ISSUE: begin
            state_d = WAIT;
         end

         WAIT: begin
            if (!in_mem_wait) begin
               // Capture the data for reads and writes alike.
               if (grant) begin
                  rdata_1_d = in_mem_rdata;
                  done_1_d  = 1'b1;
               end else begin
                  rdata_0_d = in_mem_rdata;
                  done_0_d  = 1'b1;
               end
               state_d = DONE;
            end else if (timeout_hit_c) begin
               // Abort: complete the transaction with zero data and flag it.
               if (grant) begin
                  rdata_1_d = '0;
                  done_1_d  = 1'b1;
               end else begin
                  rdata_0_d = '0;
                  done_0_d  = 1'b1;
               end
               timeout_d  = 1'b1;
               wait_cnt_d = cnt_inc_c;
               state_d    = DONE;
            end else begin
               wait_cnt_d = cnt_inc_c;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs. Reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= 1'b0;
         last_grant    <= 1'b1;
         wait_cnt      <= '0;
         out_mem_req   <= 1'b0;
         out_mem_we    <= 1'b0;
         out_mem_addr  <= '0;
         out_mem_wdata <= '0;
         out_done_0    <= 1'b0;
         out_done_1    <= 1'b0;
         out_rdata_0   <= '0;
         out_rdata_1   <= '0;
         out_timeout   <= 1'b0;
      end else begin
         state         <= state_d;
         grant         <= grant_d;
         last_grant    <= last_grant_d;
         wait_cnt      <= wait_cnt_d;
         out_mem_req   <= mem_req_d;
         out_mem_we    <= mem_we_d;
         out_mem_addr  <= mem_addr_d;
         out_mem_wdata <= mem_wdata_d;
         out_done_0    <= done_0_d;
         out_done_1    <= done_1_d;
         out_rdata_0   <= rdata_0_d;
         out_rdata_1   <= rdata_1_d;
         out_timeout   <= timeout_d;
      end
   end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a behavioural 4-wait-cycle MainMem.
module tb_main_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0;
   logic        we0 = 1'b0, we1 = 1'b0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        done0, done1;
   logic [31:0] rdata0, rdata1;
   logic        tmo;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_wait = 1'b0;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   // Memory model state
   logic [31:0] mem [0:255];
   logic        mem_init = 1'b1;
   logic        hang = 1'b0;
   int          mcnt = 0;
   logic        both_seen = 1'b0;

   int          n, oth, cnt_req, cnt_done, ng;
   logic        stable;
   logic [31:0] gaddr [0:3];

   main_mem_arbiter #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .in_req_0(req0), .in_req_1(req1),
      .in_addr_0(addr0), .in_addr_1(addr1),
      .in_we_0(we0), .in_we_1(we1),
      .in_wdata_0(wdata0), .in_wdata_1(wdata1),
      .out_done_0(done0), .out_done_1(done1),
      .out_rdata_0(rdata0), .out_rdata_1(rdata1),
      .out_timeout(tmo),
      .out_mem_req(mem_req), .out_mem_we(mem_we),
      .out_mem_addr(mem_addr), .out_mem_wdata(mem_wdata),
      .in_mem_wait(mem_wait), .in_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // MainMem: wait high for 4 cycles after a request (forever while hang is set).
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[64] <= 32'hDEADBEEF;
         mem[65] <= 32'hCAFEF00D;
      end else if (mem_req === 1'b1) begin
         if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
         mem_wait <= 1'b1;
         mcnt     <= 3;
      end else if (mem_wait && !hang) begin
         if (mcnt == 0) mem_wait <= 1'b0;
         else mcnt <= mcnt - 1;
      end
   end
   assign mem_rdata = mem[mem_addr[9:2]];

   // Both done pulses in one cycle is never legal.
   always @(posedge clk) if (done0 === 1'b1 && done1 === 1'b1) both_seen <= 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Tick until the given port's done pulse (bounded); counts the other port's pulses.
   task automatic wait_done(input int port, input int max, output int cyc, output int other);
      cyc = 0;
      other = 0;
      do begin
         tick();
         cyc++;
         if ((port == 0 ? done1 : done0) === 1'b1) other++;
      end while (!((port == 0 ? done0 : done1) === 1'b1) && cyc < max);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      mem_init = 1'b0;
      rst = 1'b0;
      chk("rst_done0", 32'(done0), 32'd0);
      chk("rst_done1", 32'(done1), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_rdata", rdata0 | rdata1 | mem_wdata, 32'h0);
      chk("rst_timeout", 32'(tmo), 32'd0);

      // Port 0 read of 0x100 alone
      req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0;
      tick();
      chk("rd0_issue_req", 32'(mem_req), 32'd1);
      chk("rd0_issue_addr", mem_addr, 32'h100);
      chk("rd0_issue_we", 32'(mem_we), 32'd0);
      wait_done(0, 20, n, oth);
      chk("rd0_latency", 32'(n), 32'd6);
      chk("rd0_rdata", rdata0, 32'hDEADBEEF);
      chk("rd0_no_done1", 32'(oth), 32'd0);
      req0 = 1'b0;
      tick();
      chk("rd0_done_one_cycle", 32'(done0), 32'd0);

      // Port 1 write of 0x12345678 to 0x20, fields stable ISSUE..DONE
      req1 = 1'b1; addr1 = 32'h20; we1 = 1'b1; wdata1 = 32'h12345678;
      tick();
      chk("wr1_issue_req", 32'(mem_req), 32'd1);
      chk("wr1_issue_we", 32'(mem_we), 32'd1);
      chk("wr1_issue_addr", mem_addr, 32'h20);
      chk("wr1_issue_wdata", mem_wdata, 32'h12345678);
      stable = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (!(mem_we === 1'b1 && mem_addr === 32'h20 && mem_wdata === 32'h12345678)) stable = 1'b0;
      end while (done1 !== 1'b1 && n < 20);
      chk("wr1_done_seen", 32'(done1), 32'd1);
      chk("wr1_fields_stable", 32'(stable), 32'd1);
      req1 = 1'b0; we1 = 1'b0;
      tick();

      // Read back 0x20 on port 1
      req1 = 1'b1; addr1 = 32'h20;
      wait_done(1, 20, n, oth);
      chk("rb1_rdata", rdata1, 32'h12345678);
      req1 = 1'b0;
      tick();

      // Port 0 changes its address right after the grant
      req0 = 1'b1; addr0 = 32'h100;
      tick();
      chk("chg_issue_addr", mem_addr, 32'h100);
      addr0 = 32'h20;
      stable = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (mem_addr !== 32'h100) stable = 1'b0;
      end while (done0 !== 1'b1 && n < 20);
      chk("chg_addr_held", 32'(stable), 32'd1);
      chk("chg_rdata", rdata0, 32'hDEADBEEF);
      req0 = 1'b0;
      tick();

      // Simultaneous requests after reset alternate 0,1,0,1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0 = 1'b1; addr0 = 32'h100;
      req1 = 1'b1; addr1 = 32'h104;
      ng = 0;
      n = 0;
      while (ng < 4 && n < 100) begin
         tick();
         n++;
         if (mem_req === 1'b1) begin
            gaddr[ng] = mem_addr;
            ng++;
         end
      end
      // Dropping requests after the last grant must not cancel it
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_grant_count", 32'(ng), 32'd4);
      chk("rr_grant0", gaddr[0], 32'h100);
      chk("rr_grant1", gaddr[1], 32'h104);
      chk("rr_grant2", gaddr[2], 32'h100);
      chk("rr_grant3", gaddr[3], 32'h104);
      wait_done(1, 20, n, oth);
      chk("rr_dropped_done1", 32'(done1), 32'd1);
      chk("rr_last_rdata", rdata1, 32'hCAFEF00D);
      tick();

      // MainMem stuck: abort after 64 WAIT cycles
      hang = 1'b1;
      req0 = 1'b1; addr0 = 32'h100;
      tick();
      chk("to_issue_req", 32'(mem_req), 32'd1);
      wait_done(0, 100, n, oth);
      chk("to_latency", 32'(n), 32'd65);
      chk("to_rdata_zero", rdata0, 32'h0);
      chk("to_flag_set", 32'(tmo), 32'd1);
      req0 = 1'b0;
      hang = 1'b0;
      tick();

      // Timeout flag is sticky across a good transaction
      req1 = 1'b1; addr1 = 32'h104;
      wait_done(1, 50, n, oth);
      chk("to_next_rdata", rdata1, 32'hCAFEF00D);
      chk("to_flag_sticky", 32'(tmo), 32'd1);
      req1 = 1'b0;
      tick();

      // Reset during WAIT while MainMem is busy
      hang = 1'b1;
      req0 = 1'b1; addr0 = 32'h100;
      tick();
      chk("mr_issue_req", 32'(mem_req), 32'd1);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_timeout_cleared", 32'(tmo), 32'd0);
      cnt_req = 0;
      cnt_done = 0;
      repeat (20) begin
         tick();
         if (mem_req === 1'b1) cnt_req++;
         if (done0 === 1'b1 || done1 === 1'b1) cnt_done++;
      end
      chk("mr_no_req_while_wait", 32'(cnt_req), 32'd0);
      chk("mr_no_done", 32'(cnt_done), 32'd0);
      hang = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (mem_req !== 1'b1 && n < 20);
      chk("mr_regrant_req", 32'(mem_req), 32'd1);
      chk("mr_regrant_addr", mem_addr, 32'h100);
      wait_done(0, 20, n, oth);
      chk("mr_regrant_rdata", rdata0, 32'hDEADBEEF);
      req0 = 1'b0;
      tick();

      chk("never_both_done", 32'(both_seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute guard against a hung run.
   initial begin
      #200000;
      $display("FAIL tb_timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
